sprite_ram_writer: RTL
======================

Name: sprite_ram_writer

Overview:
Writer side of the sprite pixel path. Accepts a row-major stream of 6-bit RRGGBB pixels over a valid/ready handshake. Writes each frame into the back half of a double-buffered 124x162 sprite RAM. At the next vertical-blank rising edge it swaps banks, so the raster-side reader always fetches a complete, stable frame from rd_bank.

Parameters:
SPR_W, 124, sprite width in pixels
SPR_H, 162, sprite height in lines
PIX_W, 6, pixel width (2 bits each R, G, B)
ADDR_W, 15, per-bank address width; SPR_W*SPR_H must be <= 2**ADDR_W

Ports:
vga_clk  in  1  single clock for the block
reset  in  1  synchronous, active-high
pix_data  in  PIX_W  incoming pixel
pix_valid  in  1  pix_data valid this cycle
pix_sof  in  1  qualifies the beat as first pixel of a frame
pix_ready  out  1  block accepts the beat this cycle
vblank  in  1  level, high during vertical blanking, from VGA timing
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W+1  {bank, offset}; bank = ~rd_bank
wr_data  out  PIX_W  RAM write data
rd_bank  out  1  bank the raster reader must use
frame_done  out  1  one-cycle pulse on bank swap
frame_err  out  1  one-cycle pulse on malformed frame
busy  out  1  high when state != IDLE

Behaviour:
- Clock/reset: one clock, vga_clk. Reset is synchronous and active-high.
- Handshake: a beat is accepted when pix_valid && pix_ready.
- pix_ready is a decode of registered state: 1 in IDLE and WRITE, 0 in WAIT_SWAP and while reset is asserted.
- Reset values: state=IDLE, col=0, row=0, offset=0, rd_bank=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_err=0, busy=0, vblank_q=1.
- vblank_q is reset to 1 so that vblank already high at reset is not taken as an edge.
- Write latency: wr_en/wr_addr/wr_data are registered and appear exactly 1 cycle after the accepted beat. wr_en is 0 in all other cycles.
- Address arithmetic: offset = row*SPR_W + col, kept as an incrementing counter (no multiplier).
  - col wraps SPR_W-1 -> 0 and increments row.
  - Last pixel is offset SPR_W*SPR_H-1 = 20087 (default).
- State IDLE:
  - Accepted beat with pix_sof=0: dropped; no write, no error.
  - Accepted beat with pix_sof=1: written at offset 0; col=1; go to WRITE.
- State WRITE:
  - Each accepted beat is written at the current offset, then counters advance.
  - Accepted beat with pix_sof=1 (early sof): frame_err pulse; beat written at offset 0; counters restart (col=1, row=0); stay in WRITE.
  - Accepting offset 20087: go to WAIT_SWAP; a pix_sof on that last beat is ignored.
- State WAIT_SWAP:
  - pix_ready=0; no writes.
  - Rising edge of vblank is vblank && !vblank_q.
  - On the edge: rd_bank toggles, frame_done=1 for one cycle, go to IDLE.
  - A vblank edge in the same cycle the last pixel is accepted does not count; the next rising edge is required.
  - vblank already high on entry does not count; a fresh rising edge is required.
- Stall: pix_valid low in WRITE holds counters; no timeout.
- Reset mid-frame: partial frame abandoned; the write owed for a beat accepted in the reset cycle is suppressed (wr_en=0 next cycle); rd_bank returns to 0.
- Bank relation: the write bank is always ~rd_bank, i.e. bank 1 after reset. The reader never sees a partially written bank.
- frame_done and frame_err are never asserted in the same cycle.

Test Plan:
- Reset, then stream 20088 beats, sof on first, pix_data = index mod 64, no gaps -> wr_en 1 cycle after each beat; wr_addr = {1'b1, offset} for offsets 0..20087; wr_data matches; busy=1; pix_ready=0 after the last beat; rd_bank=0 until vblank.
- After a full frame, raise vblank -> one cycle after the edge rd_bank=1 and frame_done=1 for exactly one cycle; state IDLE, pix_ready=1. Next frame writes to bank 0 (wr_addr[15]=0).
- In IDLE, send 5 beats with sof=0, then a sof beat -> first 5 produce no wr_en; the sof beat writes offset 0; frame_err stays 0.
- After 300 pixels, send a beat with sof=1 -> frame_err pulses once; that beat written at offset 0; following beat at offset 1. The frame completes only after 20088 pixels counted from the new sof.
- vblank held high while the last pixel is accepted -> no swap. vblank low then high -> swap on that edge. Also toggle pix_valid randomly mid-frame -> offsets stay contiguous with no skipped or duplicated addresses.
- Assert reset at offset 5000 with pix_valid=1 -> next cycle wr_en=0, rd_bank=0, busy=0, state IDLE; a new sof frame restarts at offset 0 in bank 1.

Source files
------------

// File: rtl/sprite_ram_writer.sv
`timescale 1ns/1ps
// sprite_ram_writer: takes a row-major RRGGBB pixel stream and writes each
// frame into the back bank of a double-buffered sprite RAM. Banks swap on the
// first vblank rising edge after a frame completes, so the raster reader only
// ever sees whole frames. SPR_W and SPR_H are expected to be >= 2.
module sprite_ram_writer #(
  parameter int SPR_W  = 124,
  parameter int SPR_H  = 162,
  parameter int PIX_W  = 6,
  parameter int ADDR_W = 15
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              vblank,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              rd_bank,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int COL_W = $clog2(SPR_W);
  localparam int ROW_W = $clog2(SPR_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SPR_H - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic                rd_bank_q, rd_bank_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]    wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;
  logic                vblank_q, vblank_d;

  // Per-cycle decisions shared between the next-state and output logic.
  logic                accept;
  logic                last_pix;
  logic                vblank_rise;
  logic                do_write;
  logic [ADDR_W-1:0]   write_offset;
  logic                early_sof;
  logic                swap;

  // Ready is held low during reset so no beat can be accepted (and no write
  // owed) in the reset cycle.
  assign pix_ready   = !reset && (state_q != WAIT_SWAP);
  assign busy        = (state_q != IDLE);
  assign accept      = pix_valid && pix_ready;
  assign last_pix    = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign vblank_rise = vblank && !vblank_q;

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_bank    = rd_bank_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

  // State register: all flops, synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      offset_q     <= '0;
      rd_bank_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      vblank_q     <= 1'b1;  // vblank high out of reset is not an edge
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      offset_q     <= offset_d;
      rd_bank_q    <= rd_bank_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      vblank_q     <= vblank_d;
    end
  end

  // Next-state logic: frame sequencing and the row/col/offset counters.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    offset_d     = offset_q;
    do_write     = 1'b0;
    write_offset = offset_q;
    early_sof    = 1'b0;
    swap         = 1'b0;
    case (state_q)
      IDLE: begin
        // Beats before a start-of-frame are silently dropped.
        if (accept && pix_sof) begin
          do_write     = 1'b1;
          write_offset = '0;
          col_d        = COL_W'(1);
          row_d        = '0;
          offset_d     = ADDR_W'(1);
          state_d      = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          do_write = 1'b1;
          if (last_pix) begin
            // sof on the final beat is ignored; the frame is complete.
            col_d    = '0;
            row_d    = '0;
            offset_d = '0;
            state_d  = WAIT_SWAP;
          end else if (pix_sof) begin
            // Early sof: restart the frame with this beat as pixel 0.
            early_sof    = 1'b1;
            write_offset = '0;
            col_d        = COL_W'(1);
            row_d        = '0;
            offset_d     = ADDR_W'(1);
          end else begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            offset_d = offset_q + ADDR_W'(1);
          end
        end
      end
      WAIT_SWAP: begin
        // Only a rising edge seen while waiting counts; an edge in the cycle
        // the last pixel was taken has already been absorbed into vblank_q.
        if (vblank_rise) begin
          swap    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: registered RAM write port, bank select and status pulses.
  always_comb begin
    wr_en_d      = do_write;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = swap;
    frame_err_d  = early_sof;
    rd_bank_d    = rd_bank_q ^ swap;
    vblank_d     = vblank;
    if (do_write) begin
      wr_addr_d = {~rd_bank_q, write_offset};
      wr_data_d = pix_data;
    end
  end

endmodule
